// File: rtl/cache_controller.sv
// cache_controller
//   Sequencing FSM between a CPU request port, a direct-mapped cache and main
//   memory. Reads look up the cache and, on a miss, fetch the block from
//   memory and fill the cache line. Writes go straight through to memory
//   and invalidate the cached line. Saturating hit/miss statistics are kept.
//
//   State table:
//     IDLE     | waiting for cpu_req; latches address/data on accept
//     LOOKUP   | one-cycle cache lookup, decides hit or miss
//     MEM_READ | block fetch from memory, held until mem_ready
//     FILL     | one-cycle write of the fetched block into the cache line
//     WRITE    | write-through to memory, held until mem_ready
//     RESPOND  | one-cycle cpu_ready completion pulse
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   cpu_req/we/addr/wdata    CPU request (sampled only in IDLE)
//   cpu_rdata, cpu_ready     CPU response (registered data, 1-cycle pulse)
//   cache_*                  cache lookup / fill / invalidate interface
//   mem_*                    main memory read/write handshake
//   hit_count, miss_count    saturating read hit/miss statistics

module cache_controller #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_read_en,
    output logic              cache_fill_en,
    output logic              cache_invalidate,
    input  logic              cache_hit,
    input  logic [WORD_W-1:0] cache_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_READ = 3'd2,
        FILL     = 3'd3,
        WRITE    = 3'd4,
        RESPOND  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    // Marks the first WRITE cycle so the invalidate strobe is a single pulse
    // even when the memory write stalls for many cycles.
    logic                inv_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = cpu_we ? WRITE : LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = cache_hit ? RESPOND : MEM_READ;
            end
            MEM_READ: begin
                if (mem_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next = RESPOND;
            end
            WRITE: begin
                if (mem_ready) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            inv_pending <= 1'b0;
            cpu_rdata   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q      <= cpu_addr;
                        wdata_q     <= cpu_wdata;
                        inv_pending <= cpu_we;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        cpu_rdata <= cache_rdata;
                        if (hit_count != {CNT_W{1'b1}}) begin
                            hit_count <= hit_count + 1'b1;
                        end
                    end else begin
                        if (miss_count != {CNT_W{1'b1}}) begin
                            miss_count <= miss_count + 1'b1;
                        end
                    end
                end
                MEM_READ: begin
                    if (mem_ready) begin
                        cpu_rdata <= mem_rdata;
                    end
                end
                WRITE: begin
                    inv_pending <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore strobes: decoded from registered state only.
    assign cache_read_en    = (state == LOOKUP);
    assign mem_read_en      = (state == MEM_READ);
    assign cache_fill_en    = (state == FILL);
    assign mem_write_en     = (state == WRITE);
    assign cache_invalidate = (state == WRITE) && inv_pending;
    assign cpu_ready        = (state == RESPOND);

    assign cache_addr = addr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [14:0] cache_addr;
    logic        cache_read_en;
    logic        cache_fill_en;
    logic        cache_invalidate;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
    logic [31:0] s_cpu_rdata;
    logic        s_cpu_ready;
    logic [14:0] s_cache_addr;
    logic        s_cache_read_en;
    logic        s_cache_fill_en;
    logic        s_cache_invalidate;
    logic [14:0] s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic        s_mem_read_en;
    logic        s_mem_write_en;
    logic [1:0]  s_hit_count;
    logic [1:0]  s_miss_count;

    int vectors = 0;
    int errors  = 0;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cache_addr(cache_addr), .cache_read_en(cache_read_en), .cache_fill_en(cache_fill_en),
        .cache_invalidate(cache_invalidate), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(s_cpu_rdata), .cpu_ready(s_cpu_ready),
        .cache_addr(s_cache_addr), .cache_read_en(s_cache_read_en), .cache_fill_en(s_cache_fill_en),
        .cache_invalidate(s_cache_invalidate), .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_read_en(s_mem_read_en),
        .mem_write_en(s_mem_write_en), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_hit(input logic [14:0] addr, input logic [31:0] data);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = addr;
        tick();
        cpu_req     = 1'b0;
        cache_hit   = 1'b1;
        cache_rdata = data;
        check("hitloop_read_en", 32'(cache_read_en), 32'd1);
        tick();
        check("hitloop_ready", 32'(cpu_ready), 32'd1);
        check("hitloop_rdata", cpu_rdata, data);
        cache_hit = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cache_hit = 1'b0; cache_rdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick();
        tick();
        check("rst_ready",     32'(cpu_ready), 32'd0);
        check("rst_read_en",   32'(cache_read_en), 32'd0);
        check("rst_mem_rd",    32'(mem_read_en), 32'd0);
        check("rst_hits",      32'(hit_count), 32'd0);
        check("rst_rdata",     cpu_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a block fetch.
        cpu_req = 1'b1; cpu_addr = 15'h0100;
        tick();
        cpu_req = 1'b0;
        tick();
        check("pre_rst_mem_rd", 32'(mem_read_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_mem_rd",  32'(mem_read_en), 32'd0);
        check("mid_rst_miss",    32'(miss_count), 32'd0);
        check("mid_rst_addr",    32'(cache_addr), 32'd0);
        check("mid_rst_ready",   32'(cpu_ready), 32'd0);
        #2 rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ready = 1'b0;
        check("post_rst_fill",  32'(cache_fill_en), 32'd0);
        check("post_rst_ready", 32'(cpu_ready), 32'd0);
        tick();
        check("post_rst_fill2",  32'(cache_fill_en), 32'd0);
        check("post_rst_ready2", 32'(cpu_ready), 32'd0);
        check("post_rst_rdata",  cpu_rdata, 32'd0);

        // Cold read miss of 0x0400, memory answers on the 3rd MEM_READ cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0400;
        tick();
        cpu_req = 1'b0; cache_hit = 1'b0;
        check("miss_lookup", 32'(cache_read_en), 32'd1);
        check("miss_caddr",  32'(cache_addr), 32'h0400);
        tick();
        check("miss_count1", 32'(miss_count), 32'd1);
        check("miss_mrd1",   32'(mem_read_en), 32'd1);
        tick();
        check("miss_mrd2",   32'(mem_read_en), 32'd1);
        tick();
        check("miss_mrd3",   32'(mem_read_en), 32'd1);
        check("miss_maddr",  32'(mem_addr), 32'h0400);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        check("miss_fill",       32'(cache_fill_en), 32'd1);
        check("miss_fill_mrd",   32'(mem_read_en), 32'd0);
        check("miss_fill_ready", 32'(cpu_ready), 32'd0);
        tick();
        check("miss_fill_once", 32'(cache_fill_en), 32'd0);
        check("miss_ready",     32'(cpu_ready), 32'd1);
        check("miss_rdata",     cpu_rdata, 32'hDEAD_BEEF);
        tick();
        check("miss_ready_pulse", 32'(cpu_ready), 32'd0);
        check("miss_hits",        32'(hit_count), 32'd0);

        // Read hit of 0x0400.
        cpu_req = 1'b1; cpu_addr = 15'h0400;
        tick();
        cpu_req = 1'b0; cache_hit = 1'b1; cache_rdata = 32'hDEAD_BEEF;
        check("hit_lookup", 32'(cache_read_en), 32'd1);
        check("hit_mrd_a",  32'(mem_read_en), 32'd0);
        tick();
        check("hit_ready", 32'(cpu_ready), 32'd1);
        check("hit_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("hit_count", 32'(hit_count), 32'd1);
        check("hit_miss",  32'(miss_count), 32'd1);
        check("hit_mrd_b", 32'(mem_read_en), 32'd0);
        cache_hit = 1'b0; cache_rdata = '0;
        tick();
        check("hit_mrd_c", 32'(mem_read_en), 32'd0);

        // Write-through of 0x12345678 to 0x0400, mem_ready on the 2nd cycle.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0400; cpu_wdata = 32'h1234_5678;
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        check("wr_inval1", 32'(cache_invalidate), 32'd1);
        check("wr_mwe1",   32'(mem_write_en), 32'd1);
        check("wr_wdata",  mem_wdata, 32'h1234_5678);
        check("wr_lookup", 32'(cache_read_en), 32'd0);
        tick();
        check("wr_inval2", 32'(cache_invalidate), 32'd0);
        check("wr_mwe2",   32'(mem_write_en), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("wr_ready", 32'(cpu_ready), 32'd1);
        check("wr_mwe3",  32'(mem_write_en), 32'd0);
        check("wr_hits",  32'(hit_count), 32'd1);
        check("wr_miss",  32'(miss_count), 32'd1);
        check("wr_rdata", cpu_rdata, 32'hDEAD_BEEF);
        tick();

        // Re-read after invalidate misses; memory answers on the first cycle.
        cpu_req = 1'b1; cpu_addr = 15'h0400;
        tick();
        cpu_req = 1'b0; cache_hit = 1'b0;
        tick();
        check("rerd_miss", 32'(miss_count), 32'd2);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ready = 1'b0;
        check("rerd_fill", 32'(cache_fill_en), 32'd1);
        tick();
        check("rerd_ready", 32'(cpu_ready), 32'd1);
        check("rerd_rdata", cpu_rdata, 32'h0BAD_F00D);
        tick();

        // cpu_req held high through a whole miss.
        cpu_req = 1'b1; cpu_addr = 15'h0400; cache_hit = 1'b0;
        tick();
        check("hold_lookup", 32'(cache_read_en), 32'd1);
        tick();
        check("hold_mrd",    32'(mem_read_en), 32'd1);
        check("hold_no_lk",  32'(cache_read_en), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 1'b0;
        check("hold_fill", 32'(cache_fill_en), 32'd1);
        tick();
        check("hold_ready", 32'(cpu_ready), 32'd1);
        check("hold_rdata", cpu_rdata, 32'hCAFE_F00D);
        tick();
        check("hold_idle_ready", 32'(cpu_ready), 32'd0);
        check("hold_idle_lk",    32'(cache_read_en), 32'd0);
        check("hold_miss",       32'(miss_count), 32'd3);
        cache_hit = 1'b1; cache_rdata = 32'h1111_1111;
        tick();
        cpu_req = 1'b0;
        check("hold_reaccept", 32'(cache_read_en), 32'd1);
        tick();
        check("hold2_ready", 32'(cpu_ready), 32'd1);
        check("hold2_rdata", cpu_rdata, 32'h1111_1111);
        check("hold2_hits",  32'(hit_count), 32'd2);
        check("sat_hits2",   32'(s_hit_count), 32'd2);
        cache_hit = 1'b0;
        tick();

        // Three more hits: narrow counter pins at its maximum.
        for (int i = 0; i < 3; i++) begin
            do_hit(15'(16'h0200 + i), 32'hA000_0000 + 32'(i));
        end
        check("sat_hits_max", 32'(s_hit_count), 32'd3);
        check("sat_miss",     32'(s_miss_count), 32'd3);
        check("main_hits5",   32'(hit_count), 32'd5);
        check("main_miss3",   32'(miss_count), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
